// File: rtl/debug_probe_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : debug_probe_scanner
//  Purpose  : Selects one of CHANNELS packed probe words onto a registered
//             display word, by manual select or timed round-robin scanning,
//             with an optional frozen snapshot of every channel.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_probe_scanner #(
  parameter int REGISTER_WIDTH = 8,
  parameter int CHANNELS       = 4,
  parameter int SEL_WIDTH      = $clog2(CHANNELS),
  parameter int DWELL_CYCLES   = 50_000_000
) (
  input  logic                               clock,
  input  logic                               isReset,
  input  logic [CHANNELS*REGISTER_WIDTH-1:0] probeBus,
  input  logic [SEL_WIDTH-1:0]               select,
  input  logic                               scanMode,
  input  logic                               freeze,
  output logic [REGISTER_WIDTH-1:0]          outputValue,
  output logic [SEL_WIDTH-1:0]               channel,
  output logic                               channelStrobe
);

  localparam int                      c_DWELL_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [c_DWELL_W-1:0]    c_DWELL_LAST = c_DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [c_DWELL_W-1:0]    c_DWELL_ONE  = c_DWELL_W'(1);
  localparam logic [SEL_WIDTH-1:0]    c_LAST_CH    = SEL_WIDTH'(CHANNELS - 1);
  localparam logic [SEL_WIDTH-1:0]    c_SEL_ONE    = SEL_WIDTH'(1);
  localparam int                      c_SLOTS      = 2 ** SEL_WIDTH;

  logic [c_DWELL_W-1:0]               r_dwell;
  logic [SEL_WIDTH-1:0]               r_scan_idx;
  logic                               r_scan_d;
  logic                               r_freeze_d;
  logic                               r_frozen;
  logic [CHANNELS*REGISTER_WIDTH-1:0] r_snap;

  logic                               w_entry;
  logic                               w_dwell_done;
  logic [SEL_WIDTH-1:0]               w_base;
  logic [SEL_WIDTH-1:0]               w_next_idx;
  logic [SEL_WIDTH-1:0]               w_cur_idx;
  logic [CHANNELS*REGISTER_WIDTH-1:0] w_source;
  logic                               w_freeze_rise;
  logic [REGISTER_WIDTH-1:0]          w_words [c_SLOTS];

  // Entering scan mode starts from the select value seen on that very edge.
  assign w_entry       = scanMode & ~r_scan_d;
  assign w_base        = w_entry ? select : r_scan_idx;
  assign w_dwell_done  = (r_dwell == c_DWELL_LAST);
  assign w_next_idx    = (w_base >= c_LAST_CH) ? '0 : (w_base + c_SEL_ONE);
  assign w_cur_idx     = scanMode ? w_base : select;
  assign w_source      = r_frozen ? r_snap : probeBus;
  assign w_freeze_rise = freeze & ~r_freeze_d;

  // Slots beyond CHANNELS read as zero, covering out-of-range indices.
  generate
    for (genvar k = 0; k < c_SLOTS; k++) begin : g_slot
      if (k < CHANNELS) begin : g_live
        assign w_words[k] = w_source[k*REGISTER_WIDTH +: REGISTER_WIDTH];
      end else begin : g_pad
        assign w_words[k] = '0;
      end
    end
  endgenerate

  // The scan-mode history resets high so a scan already requested at reset
  // release restarts from channel 0 rather than reloading select.
  always_ff @(posedge clock or negedge isReset) begin
    if (!isReset) begin
      r_dwell    <= '0;
      r_scan_idx <= '0;
      r_scan_d   <= 1'b1;
    end else begin
      r_scan_d <= scanMode;
      if (scanMode) begin
        if (w_dwell_done) begin
          r_dwell    <= '0;
          r_scan_idx <= w_next_idx;
        end else begin
          r_dwell    <= r_dwell + c_DWELL_ONE;
          r_scan_idx <= w_base;
        end
      end else begin
        r_dwell <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge isReset) begin
    if (!isReset) begin
      r_freeze_d <= 1'b0;
      r_frozen   <= 1'b0;
      r_snap     <= '0;
    end else begin
      r_freeze_d <= freeze;
      if (w_freeze_rise) begin
        r_snap   <= probeBus;
        r_frozen <= 1'b1;
      end else if (!freeze) begin
        r_frozen <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge isReset) begin
    if (!isReset) begin
      outputValue   <= '0;
      channel       <= '0;
      channelStrobe <= 1'b0;
    end else begin
      outputValue   <= w_words[w_cur_idx];
      channel       <= w_cur_idx;
      channelStrobe <= (w_cur_idx != channel);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_probe_scanner.sv
`default_nettype none
// Testbench for debug_probe_scanner: directed vector table, hand-written
// scan/freeze/reset sequences, and randomized traffic against a reference model.
module tb_debug_probe_scanner;

  logic        clock = 1'b0;
  logic        isReset;
  logic [31:0] probe_a;
  logic [1:0]  sel_a;
  logic        scan_a, frz_a;
  logic [7:0]  out_a;
  logic [1:0]  ch_a;
  logic        st_a;
  logic [23:0] probe_b;
  logic [1:0]  sel_b;
  logic        scan_b, frz_b;
  logic [7:0]  out_b;
  logic [1:0]  ch_b;
  logic        st_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  debug_probe_scanner #(.REGISTER_WIDTH(8), .CHANNELS(4), .DWELL_CYCLES(3)) dut_a (
    .clock(clock), .isReset(isReset), .probeBus(probe_a), .select(sel_a),
    .scanMode(scan_a), .freeze(frz_a), .outputValue(out_a), .channel(ch_a),
    .channelStrobe(st_a)
  );

  debug_probe_scanner #(.REGISTER_WIDTH(8), .CHANNELS(3), .DWELL_CYCLES(2)) dut_b (
    .clock(clock), .isReset(isReset), .probeBus(probe_b), .select(sel_b),
    .scanMode(scan_b), .freeze(frz_b), .outputValue(out_b), .channel(ch_b),
    .channelStrobe(st_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: scan position is entry channel plus elapsed dwells.
  int          m_chs [2] = '{4, 3};
  int          m_dw  [2] = '{3, 2};
  int          m_entry [2];
  int          m_n [2];
  int          m_ch [2];
  bit          m_prev_scan [2];
  bit          m_prev_frz [2];
  bit          m_frozen [2];
  logic [31:0] m_snap [2];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_entry[u] = 0; m_n[u] = 0; m_ch[u] = 0;
      m_prev_scan[u] = 1'b1; m_prev_frz[u] = 1'b0;
      m_frozen[u] = 1'b0; m_snap[u] = '0;
    end
  endtask

  task automatic model_step(input int u, input int sel, input bit scan, input bit frz,
                            input logic [31:0] probe, output int eo, output int ec,
                            output bit es);
    int cur;
    logic [31:0] src;
    if (scan) begin
      if (!m_prev_scan[u]) begin
        m_entry[u] = sel;
        m_n[u] = 0;
      end
      cur = (m_entry[u] + m_n[u] / m_dw[u]) % m_chs[u];
      m_n[u]++;
    end else begin
      cur = sel;
    end
    src = m_frozen[u] ? m_snap[u] : probe;
    eo  = (cur < m_chs[u]) ? int'((src >> (cur * 8)) & 32'hFF) : 0;
    ec  = cur;
    es  = (cur != m_ch[u]);
    m_ch[u] = cur;
    if (frz && !m_prev_frz[u]) begin
      m_snap[u] = probe;
      m_frozen[u] = 1'b1;
    end else if (!frz) begin
      m_frozen[u] = 1'b0;
    end
    m_prev_frz[u] = frz;
    m_prev_scan[u] = scan;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        frz;
    logic [31:0] probe;
    logic [7:0]  exp_out;
    logic [1:0]  exp_ch;
    logic        exp_st;
  } vec_t;

  vec_t       vecs [11];
  logic [7:0] exp_post [13];

  function automatic int word_of(input logic [31:0] p, input int idx);
    return int'((p >> (idx * 8)) & 32'hFF);
  endfunction

  initial begin
    int eo, ec;
    bit es;

    vecs[0]  = '{2'd0, 1'b0, 32'h44332211, 8'h11, 2'd0, 1'b0};
    vecs[1]  = '{2'd1, 1'b0, 32'h44332211, 8'h22, 2'd1, 1'b1};
    vecs[2]  = '{2'd2, 1'b0, 32'h44332211, 8'h33, 2'd2, 1'b1};
    vecs[3]  = '{2'd3, 1'b0, 32'h44332211, 8'h44, 2'd3, 1'b1};
    vecs[4]  = '{2'd3, 1'b0, 32'h44332211, 8'h44, 2'd3, 1'b0};
    vecs[5]  = '{2'd0, 1'b1, 32'h44332211, 8'h11, 2'd0, 1'b1};
    vecs[6]  = '{2'd1, 1'b1, 32'hDDCCBBAA, 8'h22, 2'd1, 1'b1};
    vecs[7]  = '{2'd2, 1'b1, 32'hDDCCBBAA, 8'h33, 2'd2, 1'b1};
    vecs[8]  = '{2'd3, 1'b1, 32'hDDCCBBAA, 8'h44, 2'd3, 1'b1};
    vecs[9]  = '{2'd0, 1'b0, 32'hDDCCBBAA, 8'h11, 2'd0, 1'b1};
    vecs[10] = '{2'd0, 1'b0, 32'hDDCCBBAA, 8'hAA, 2'd0, 1'b0};
    exp_post = '{8'h55, 8'h55, 8'h55, 8'h66, 8'h56, 8'h56, 8'h34, 8'h34, 8'h34,
                 8'h12, 8'h12, 8'hA1, 8'hD4};

    isReset = 1'b0;
    probe_a = '0; sel_a = '0; scan_a = 1'b0; frz_a = 1'b0;
    probe_b = '0; sel_b = '0; scan_b = 1'b0; frz_b = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out_a", int'(out_a), 0);
    chk("reset_ch_a",  int'(ch_a),  0);
    chk("reset_st_a",  int'(st_a),  0);
    chk("reset_out_b", int'(out_b), 0);
    chk("reset_ch_b",  int'(ch_b),  0);
    isReset = 1'b1;

    // Manual selection and freeze snapshot on the 4-channel unit.
    for (int i = 0; i < 11; i++) begin
      sel_a = vecs[i].sel; frz_a = vecs[i].frz; probe_a = vecs[i].probe;
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_out", i), int'(out_a), int'(vecs[i].exp_out));
      chk($sformatf("vec%0d_ch", i),  int'(ch_a),  int'(vecs[i].exp_ch));
      chk($sformatf("vec%0d_st", i),  int'(st_a),  int'(vecs[i].exp_st));
    end

    // Out-of-range index on the 3-channel unit.
    probe_b = 24'hCCBBAA;
    for (int i = 0; i < 5; i++) begin
      int s_tab [5]  = '{3, 3, 1, 0, 2};
      int o_tab [5]  = '{0, 0, 'hBB, 'hAA, 'hCC};
      int st_tab [5] = '{1, 0, 1, 1, 1};
      sel_b = 2'(s_tab[i]);
      @(posedge clock);
      #1;
      chk($sformatf("b_oor%0d_out", i), int'(out_b), o_tab[i]);
      chk($sformatf("b_oor%0d_ch", i),  int'(ch_b),  s_tab[i]);
      chk($sformatf("b_oor%0d_st", i),  int'(st_b),  st_tab[i]);
    end

    // Scan entry from select=2, dwell of three cycles.
    sel_a = 2'd2; scan_a = 1'b1; frz_a = 1'b0; probe_a = 32'h44332211;
    for (int i = 0; i < 13; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("scan%0d_ch", i),  int'(ch_a),  (2 + i / 3) % 4);
      chk($sformatf("scan%0d_out", i), int'(out_a), word_of(32'h44332211, (2 + i / 3) % 4));
      chk($sformatf("scan%0d_st", i),  int'(st_a),  (i % 3 == 0) ? 1 : 0);
      sel_a = 2'd0;
    end

    // Freeze at channel 2, then asynchronous reset mid-cycle.
    frz_a = 1'b1;
    @(posedge clock);
    #1;
    chk("pre_rst_ch", int'(ch_a), 2);
    #2;
    isReset = 1'b0;
    #1;
    chk("async_rst_out", int'(out_a), 0);
    chk("async_rst_ch",  int'(ch_a),  0);
    chk("async_rst_st",  int'(st_a),  0);
    probe_a = 32'h88776655;
    @(posedge clock);
    #3;
    isReset = 1'b1;

    // Restart at channel 0, re-snapshot, then freeze coincident with wrap 3->0.
    for (int e = 0; e < 13; e++) begin
      @(posedge clock);
      #1;
      chk($sformatf("post%0d_ch", e),  int'(ch_a),  (e / 3) % 4);
      chk($sformatf("post%0d_out", e), int'(out_a), int'(exp_post[e]));
      chk($sformatf("post%0d_st", e),  int'(st_a),  (e > 0 && e % 3 == 0) ? 1 : 0);
      if (e == 0) probe_a = 32'h12345678;
      if (e == 2) frz_a = 1'b0;
      if (e == 10) begin frz_a = 1'b1; probe_a = 32'hA1B2C3D4; end
      if (e == 11) probe_a = 32'h0F0E0D0C;
    end

    // Randomized traffic on both units against the model.
    frz_a = 1'b0; scan_a = 1'b0; frz_b = 1'b0; scan_b = 1'b0;
    isReset = 1'b0;
    #2;
    isReset = 1'b1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 19) == 0) scan_a = ~scan_a;
      if ($urandom_range(0, 5) == 0)  frz_a  = ~frz_a;
      sel_a   = 2'($urandom_range(0, 3));
      probe_a = $urandom;
      if ($urandom_range(0, 19) == 0) scan_b = ~scan_b;
      if ($urandom_range(0, 5) == 0)  frz_b  = ~frz_b;
      sel_b   = scan_b ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
      probe_b = 24'($urandom);
      @(posedge clock);
      model_step(0, int'(sel_a), scan_a, frz_a, probe_a, eo, ec, es);
      #1;
      chk("rnd_a_out", int'(out_a), eo);
      chk("rnd_a_ch",  int'(ch_a),  ec);
      chk("rnd_a_st",  int'(st_a),  int'(es));
      model_step(1, int'(sel_b), scan_b, frz_b, {8'h00, probe_b}, eo, ec, es);
      chk("rnd_b_out", int'(out_b), eo);
      chk("rnd_b_ch",  int'(ch_b),  ec);
      chk("rnd_b_st",  int'(st_b),  int'(es));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
